target_sequencer: RTL

- Reader/producer side of the switch-match game datapath. Walks a synchronous target memory, presents one 8-bit target at a time on oMemValue, and judges the player's switches (iSW) against it.
- Emits one-cycle hit/miss pulses to the downstream comparator/score logic, then advances to the next target.
- Stops with oDone once the last memory entry has been judged.

---
 rtl/target_sequencer_if.sv | 44 ++++
 rtl/target_sequencer.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/target_sequencer_if.sv
// Bus bundle between the target sequencer and its environment: game control
// inputs, the target memory read port and the judged-target outputs.
interface TargetSequencerIf #(
    parameter int AW = 4
);
    logic          iStart;
    logic [7:0]    iSW;
    logic [AW-1:0] oAddr;
    logic [7:0]    iMemData;
    logic [7:0]    oMemValue;
    logic          oValid;
    logic          oHit;
    logic          oMiss;
    logic [AW-1:0] oIndex;
    logic          oDone;

    // Sequencer side: drives the memory address and the judged-target outputs
    modport master (
        input  iStart,
        input  iSW,
        input  iMemData,
        output oAddr,
        output oMemValue,
        output oValid,
        output oHit,
        output oMiss,
        output oIndex,
        output oDone
    );

    // Environment side: memory, switches, downstream score logic
    modport slave (
        output iStart,
        output iSW,
        output iMemData,
        input  oAddr,
        input  oMemValue,
        input  oValid,
        input  oHit,
        input  oMiss,
        input  oIndex,
        input  oDone
    );
endinterface

// File: rtl/target_sequencer.sv
// Target sequencer for the switch-match game. Walks a registered-output
// target ROM, presents one target at a time, debounces the player's switches
// against it and emits a one-cycle hit or miss pulse before moving on.
// DEPTH must be at least 2 so the address bus is at least one bit wide.
module target_sequencer #(
    parameter int DEPTH          = 16,
    parameter int HOLD_CYCLES    = 4,
    parameter int TIMEOUT_CYCLES = 50000000
) (
    input  logic            iClk,
    input  logic            iRst,
    TargetSequencerIf.master bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int SW = $clog2(HOLD_CYCLES + 1);

    localparam logic [AW-1:0] IDX_LAST    = AW'(DEPTH - 1);
    localparam logic [TW-1:0] TIMER_LAST  = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [SW-1:0] STABLE_LAST = SW'(HOLD_CYCLES - 1);
    localparam logic [SW-1:0] STABLE_MAX  = SW'(HOLD_CYCLES);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        PRESENT,
        DONE
    } seqState_t;

    seqState_t     state, stateNext;
    logic [AW-1:0] idx, idxNext;
    logic [7:0]    memValue, memValueNext;
    logic          valid, validNext;
    logic          hit, hitNext;
    logic          miss, missNext;
    logic          done, doneNext;
    logic [TW-1:0] timer, timerNext;
    logic [SW-1:0] stable, stableNext;
    logic          sampleMatch;

    // The address and the reported index are the same counter: the ROM is
    // always pointed at the target currently being fetched or judged.
    assign bus.oAddr     = idx;
    assign bus.oIndex    = idx;
    assign bus.oMemValue = memValue;
    assign bus.oValid    = valid;
    assign bus.oHit      = hit;
    assign bus.oMiss     = miss;
    assign bus.oDone     = done;

    assign sampleMatch = (bus.iSW == memValue);

    // State and datapath registers; reset wins over everything, including a
    // hit or miss that would otherwise land on the same edge.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            state    <= IDLE;
            idx      <= '0;
            memValue <= '0;
            valid    <= 1'b0;
            hit      <= 1'b0;
            miss     <= 1'b0;
            done     <= 1'b0;
            timer    <= '0;
            stable   <= '0;
        end else begin
            state    <= stateNext;
            idx      <= idxNext;
            memValue <= memValueNext;
            valid    <= validNext;
            hit      <= hitNext;
            miss     <= missNext;
            done     <= doneNext;
            timer    <= timerNext;
            stable   <= stableNext;
        end
    end

    // Next-state and next-output logic; hit and miss default low so each
    // pulse lasts exactly one cycle.
    always_comb begin
        stateNext    = state;
        idxNext      = idx;
        memValueNext = memValue;
        validNext    = valid;
        hitNext      = 1'b0;
        missNext     = 1'b0;
        doneNext     = done;
        timerNext    = timer;
        stableNext   = stable;

        unique case (state)
            IDLE: begin
                validNext = 1'b0;
                if (bus.iStart) begin
                    idxNext   = '0;
                    stateNext = FETCH;
                end
            end

            FETCH: begin
                validNext = 1'b0;
                doneNext  = 1'b0;
                stateNext = LOAD;
            end

            LOAD: begin
                memValueNext = bus.iMemData;
                validNext    = 1'b1;
                timerNext    = '0;
                stableNext   = '0;
                stateNext    = PRESENT;
            end

            PRESENT: begin
                if (sampleMatch) begin
                    if (stable != STABLE_MAX) begin
                        stableNext = stable + SW'(1);
                    end
                end else begin
                    stableNext = '0;
                end

                if (sampleMatch && (stable == STABLE_LAST)) begin
                    hitNext = 1'b1;
                end else if (timer == TIMER_LAST) begin
                    missNext = 1'b1;
                end else begin
                    timerNext = timer + TW'(1);
                end

                if (hitNext || missNext) begin
                    validNext = 1'b0;
                    if (idx == IDX_LAST) begin
                        doneNext  = 1'b1;
                        stateNext = DONE;
                    end else begin
                        idxNext   = idx + AW'(1);
                        stateNext = FETCH;
                    end
                end
            end

            DONE: begin
                validNext = 1'b0;
                doneNext  = 1'b1;
                if (bus.iStart) begin
                    doneNext  = 1'b0;
                    idxNext   = '0;
                    stateNext = FETCH;
                end
            end

            default: begin
                stateNext = IDLE;
                validNext = 1'b0;
            end
        endcase
    end
endmodule
